// File: rtl/pipeline_pkg.sv
// Shared types and helpers for the IF/ID fetch queue.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pipeline_pkg;

  localparam int XLEN = 32;

  // addi x0,x0,0: what decode sees when the queue has nothing to offer
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Default-width view of one queue entry (the top re-declares it at WIDTH)
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pcp4;
  } if_id_payload_t;

  // Pointer width; kept at least 1 so a degenerate depth still elaborates
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Occupancy counter width: must be able to hold the value DEPTH itself
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Generic pointer/count/storage FIFO core with synchronous clear.
// Latency: write at edge N is readable on o_rdata after edge N (no fall-through).
// Backpressure: push ignored when full, pop ignored when empty, clear beats both.
module sync_fifo_core
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_clear,
  input  logic [DATA_W-1:0]        i_wdata,
  output logic [DATA_W-1:0]        o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [cnt_w(DEPTH)-1:0]  o_count
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rptr];

  // Guard again here so the core is safe even if a caller forgets to qualify
  assign w_push = i_push & ~o_full  & ~i_clear;
  assign w_pop  = i_pop  & ~o_empty & ~i_clear;

  // Storage: no reset, stale data is masked by the consumer when empty
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
    end
  end

  // Occupancy: simultaneous push and pop leaves the count unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pipeline_if_id_queue.sv
// DEPTH-entry IF/ID fetch queue with branch-redirect flush and NOP substitution.
// Latency: one cycle from push to visibility at the head; no same-cycle fall-through.
// Backpressure: ready_F = not full (independent of ready_D); ready_D ignored when empty.
module pipeline_if_id_queue #(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 4,
  parameter logic [WIDTH-1:0] NOP_INSTR = WIDTH'(pipeline_pkg::NOP_INSTR)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         valid_F,
  output logic                         ready_F,
  input  logic [WIDTH-1:0]             instr_F,
  input  logic [WIDTH-1:0]             PC_F,
  input  logic [WIDTH-1:0]             PCP4_F,
  output logic                         valid_D,
  input  logic                         ready_D,
  output logic [WIDTH-1:0]             instr_D,
  output logic [WIDTH-1:0]             PC_D,
  output logic [WIDTH-1:0]             PCP4_D,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  // Same layout as pipeline_pkg::if_id_payload_t, sized by WIDTH
  typedef struct packed {
    logic [WIDTH-1:0] instr;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pcp4;
  } payload_t;

  payload_t w_wr;
  payload_t w_rd;
  logic     w_full;
  logic     w_empty;
  logic     w_push;
  logic     w_pop;

  assign w_wr    = '{instr: instr_F, pc: PC_F, pcp4: PCP4_F};
  assign ready_F = ~w_full;
  assign valid_D = ~w_empty;

  // Flush squashes both handshakes in the cycle it is asserted
  assign w_push = valid_F & ready_F & ~flush;
  assign w_pop  = valid_D & ready_D & ~flush;

  sync_fifo_core #(
    .DATA_W ($bits(payload_t)),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (flush),
    .i_wdata (w_wr),
    .o_rdata (w_rd),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (count)
  );

  // Hide stale storage behind a NOP bubble whenever the head is not valid
  always_comb begin
    instr_D = NOP_INSTR;
    PC_D    = '0;
    PCP4_D  = '0;
    if (valid_D) begin
      instr_D = w_rd.instr;
      PC_D    = w_rd.pc;
      PCP4_D  = w_rd.pcp4;
    end
  end

endmodule

// File: doc/pipeline_if_id_queue.md
Name: pipeline_if_id_queue

Overview:
Parametrised successor to the single-entry IF/ID pipeline register. It is a DEPTH-entry fetch queue between the fetch stage and the decode stage. It decouples fetch from decode stalls using valid/ready handshakes on both sides, supports a synchronous flush for branch redirect, and drives a NOP to decode whenever it has nothing valid to present.

Parameters:
WIDTH, 32, width of instruction, PC and PC+4 fields
DEPTH, 4, number of queue entries; power of two, minimum 2
NOP_INSTR, 32'h00000013, instruction word presented to decode when the queue is empty (addi x0,x0,0)

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; discards all queued entries
valid_F  input  1  fetch presents an entry this cycle
ready_F  output  1  queue can accept an entry; equals not-full
instr_F  input  WIDTH  fetched instruction
PC_F  input  WIDTH  PC of fetched instruction
PCP4_F  input  WIDTH  PC+4 of fetched instruction
valid_D  output  1  head entry is valid for decode
ready_D  input  1  decode consumes the head this cycle (the inverse of the legacy stall)
instr_D  output  WIDTH  head instruction, or NOP_INSTR when not valid_D
PC_D  output  WIDTH  head PC, or 0 when not valid_D
PCP4_D  output  WIDTH  head PC+4, or 0 when not valid_D
count  output  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Reset (asynchronous, while rst=1): read and write pointers = 0; count = 0; valid_D = 0; instr_D = NOP_INSTR; PC_D = 0; PCP4_D = 0; ready_F = 1.
- Push: occurs when valid_F && ready_F && !flush. The entry is written at the write pointer and the write pointer increments mod DEPTH (natural wrap, $clog2(DEPTH)-bit pointer).
- Pop: occurs when valid_D && ready_D && !flush. The read pointer increments mod DEPTH.
- Outputs are driven combinationally from the head entry's storage, but storage is only written at the clock edge. Latency is therefore one cycle: an entry pushed at edge N is visible on the D outputs after edge N, provided it is at the head.
- No same-cycle fall-through when the queue is empty.
- valid_D = (count != 0). When not valid_D, the outputs are forced to NOP_INSTR/0/0 regardless of stale storage.
- ready_F = (count != DEPTH). It does not depend on a same-cycle pop, so there is no combinational path from ready_D to ready_F.
- Push with no pop: count+1. Pop with no push: count-1. Simultaneous push and pop: count unchanged and both pointers advance. This is legal at any non-full, non-empty occupancy.
- Full (count=DEPTH): ready_F=0 and valid_F is ignored, even if a pop occurs in the same cycle.
- Empty (count=0): ready_D is ignored, and count never underflows.
- Flush (synchronous, highest priority):
  - On the next edge, both pointers reset to 0 and count resets to 0.
  - A same-cycle push and pop are both discarded.
  - The cycle after a flush, valid_D=0 and the outputs show NOP.
  - Storage contents need not be cleared.
- Flush with valid_F=1: the fetch entry is dropped. The redirected fetch is pushed on a later cycle.
- Reset asserted mid-operation: the queue empties immediately (asynchronously) and all in-flight entries are lost.
- No internal FSM beyond occupancy; the empty/partial/full status is derived from count.

Decomposition:
- Shared package pipeline_pkg:
  - typedef if_id_payload_t: packed struct {instr, pc, pcp4}, WIDTH bits each.
  - Constant NOP_INSTR.
  - Function clog2-based width helpers.
- Sub-module sync_fifo_core: parametrised (DATA_W, DEPTH) pointer/count/storage core with push, pop, clear, full, empty, count and rdata.
- The top level packs and unpacks if_id_payload_t, applies flush as clear, and applies NOP substitution.

Test Plan:
- Reset then idle: rst pulse with valid_F=0 -> valid_D=0, instr_D=0x00000013, PC_D=0, count=0, ready_F=1.
- Fill without drain: ready_D=0; push PC=0x00, 0x04, 0x08, 0x0C -> count reaches 4, ready_F=0; a 5th push of PC=0x10 is ignored; PC_D=0x00 throughout.
- Drain in order: from full, ready_D=1 for 4 cycles -> PC_D sequence 0x00, 0x04, 0x08, 0x0C, then valid_D=0 and instr_D=NOP.
- Simultaneous push/pop with wraparound: hold count=2, stream 10 entries with valid_F=ready_D=1 -> count stays 2 and PCs emerge in order across pointer wrap.
- Flush priority: count=3, flush=1 with valid_F=1 and ready_D=1 -> next cycle count=0, valid_D=0, instr_D=NOP, and the flushed-cycle fetch entry never appears.
- Async reset mid-stream: assert rst between edges with count=2 -> outputs become NOP/0 immediately (before the next edge), count=0.
